// File: rtl/mlp_seq_engine.sv
// Time-multiplexed 3-layer fixed-point MLP (N_IN -> N_H1 -> N_H2 -> 1) on a single shared MAC.
// Optional macro MLP_SAT_EN: saturate write-back to W bits instead of two's-complement wrap.
module mlp_seq_engine #(
  parameter int INTEGRAL_WIDTH = 4,
  parameter int FRACTION_WIDTH = 16,
  parameter int N_IN           = 3,
  parameter int N_H1           = 5,
  parameter int N_H2           = 3,
  parameter int AW             = 8,
  localparam int W             = INTEGRAL_WIDTH + FRACTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic signed [W-1:0]   w_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   out_score,
  output logic                  out_class
);

  localparam int ACC_W = 2*W + 4;
  localparam int B2    = N_H1*(N_IN+1);
  localparam int B3    = B2 + N_H2*(N_H1+1);
  localparam int NW    = B3 + N_H2 + 1;
  localparam int M12   = (N_IN > N_H1) ? N_IN : N_H1;
  localparam int MAXN  = (M12 > N_H2) ? M12 : N_H2;
  localparam int CW    = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int MW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WB, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          layer;
  logic [CW-1:0]       nidx;
  logic [CW-1:0]       kidx;
  logic [MW-1:0]       wptr;

  logic signed [W-1:0] wmem [NW];
  logic signed [W-1:0] xin  [MAXN];
  logic signed [W-1:0] h1   [MAXN];
  logic signed [W-1:0] h2   [MAXN];
  logic signed [ACC_W-1:0] acc;

  logic signed [W-1:0]   x_sel;
  logic signed [W-1:0]   w_rd;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] bias_sh;
  logic signed [W-1:0]   wb_val;
  int                    fanin;
  int                    ncnt;
  logic                  last_k, last_n, last_layer;
  logic                  accept, w_en;

  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [2*W-1:0] v);
    return {{(ACC_W-2*W){v[2*W-1]}}, v};
  endfunction

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

`ifdef MLP_SAT_EN
  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-FRACTION_WIDTH-1:0] v);
    if ((&v[ACC_W-FRACTION_WIDTH-1:W-1]) || (~|v[ACC_W-FRACTION_WIDTH-1:W-1]))
      return v[W-1:0];
    return v[ACC_W-FRACTION_WIDTH-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction
  assign wb_val = sat_w(acc[ACC_W-1:FRACTION_WIDTH]);
`else
  function automatic logic signed [W-1:0] wrap_w(input logic [W-1:0] v);
    return $signed(v);
  endfunction
  // The low W bits of acc >>> FRACTION_WIDTH are exactly this slice.
  assign wb_val = wrap_w(acc[FRACTION_WIDTH +: W]);
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_ready && in_valid;
  assign w_en      = in_ready && w_we && !in_valid && ({1'b0, w_addr} < (AW+1)'(NW));

  // The weight map is laid out in evaluation order, so one pointer walks it linearly.
  assign w_rd    = wmem[wptr];
  assign prod    = $signed({{W{x_sel[W-1]}}, x_sel}) * $signed({{W{w_rd[W-1]}}, w_rd});
  assign bias_sh = $signed({{W{w_rd[W-1]}}, w_rd}) <<< FRACTION_WIDTH;

  always_comb begin
    fanin = N_IN;
    ncnt  = N_H1;
    x_sel = xin[kidx];
    case (layer)
      2'd0: begin fanin = N_IN; ncnt = N_H1; x_sel = xin[kidx]; end
      2'd1: begin fanin = N_H1; ncnt = N_H2; x_sel = h1[kidx];  end
      default: begin fanin = N_H2; ncnt = 1; x_sel = h2[kidx];  end
    endcase
    last_k     = (int'(kidx) == fanin - 1);
    last_n     = (int'(nidx) == ncnt - 1);
    last_layer = (layer == 2'd2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_MAC;
      S_MAC:   if (last_k) state_nxt = S_WB;
      S_WB:    state_nxt = (last_layer && last_n) ? S_DONE : S_BIAS;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: sequencing counters and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      layer     <= '0;
      nidx      <= '0;
      kidx      <= '0;
      wptr      <= '0;
      out_score <= '0;
      out_class <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            layer <= '0;
            nidx  <= '0;
            kidx  <= '0;
            wptr  <= '0;
          end
        end
        S_BIAS: wptr <= wptr + MW'(1);
        S_MAC: begin
          wptr <= wptr + MW'(1);
          kidx <= kidx + CW'(1);
        end
        S_WB: begin
          kidx <= '0;
          if (last_n) begin
            nidx  <= '0;
            layer <= layer + 2'd1;
          end else begin
            nidx <= nidx + CW'(1);
          end
          if (last_layer) begin
            out_score <= wb_val;
            out_class <= ~wb_val[W-1] & (|wb_val);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: weight store, input capture, accumulator and activation buffers.
  always_ff @(posedge clk) begin
    if (w_en)
      wmem[w_addr[MW-1:0]] <= w_data;
    if (accept)
      for (int i = 0; i < N_IN; i++) xin[i] <= in_data[i*W +: W];
    case (state)
      S_BIAS: acc <= sext_acc(bias_sh);
      S_MAC:  acc <= acc + sext_acc(prod);
      S_WB: begin
        if (layer == 2'd0)      h1[nidx] <= relu(wb_val);
        else if (layer == 2'd1) h2[nidx] <= relu(wb_val);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mlp_seq_engine.md
# mlp_seq_engine

- Parametrised, time-multiplexed successor to the fixed 3-5-3-1 MLP classifier: a 3-layer fixed-point MLP (N_IN → N_H1 → N_H2 → 1) evaluated on one shared multiply-accumulate unit.
- Weights and biases are runtime-loadable through a write port; inference uses valid/ready handshakes on input and output.
- It sits between the feature front end and the decision logic, and returns both the raw score and the binary class.

## Interface
- INTEGRAL_WIDTH, 4, integer bits incl. sign; W = INTEGRAL_WIDTH+FRACTION_WIDTH
- FRACTION_WIDTH, 16, fractional bits
- N_IN, 3, input features
- N_H1, 5, layer-1 neurons
- N_H2, 3, layer-2 neurons
- AW, 8, weight address width; must satisfy 2^AW ≥ NW (below)

- clk  in  1  clock; all state on rising edge
- rst  in  1  **reset: asynchronous, active-high**
- w_we  in  1  weight write strobe
- w_addr  in  AW  weight address
- w_data  in  W  signed weight/bias
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine idle, accepts vector
- in_data  in  N_IN*W  feature i at [i*W +: W], signed Q(INTEGRAL_WIDTH.FRACTION_WIDTH)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_score  out  W  signed final-layer value
- out_class  out  1  1 iff out_score > 0 (strictly)

## Operation
- **Weight map** (per neuron: bias first, then weights in input order):
  - L1 neuron j at j*(N_IN+1).
  - L2 base B2 = N_H1*(N_IN+1); neuron j at B2 + j*(N_H1+1).
  - L3 base B3 = B2 + N_H2*(N_H1+1).
  - NW = B3 + N_H2 + 1. Defaults: B2 = 20, B3 = 38, NW = 42.
- **Weight writes**
  - Accepted only in IDLE.
  - Ignored while busy, or when w_addr ≥ NW.
  - Weight memory is not cleared by rst; contents are undefined until written.
- **Input capture:** in_valid & in_ready at a clock edge latches in_data into the input buffer and leaves IDLE.
- **FSM:** IDLE → BIAS → MAC ×K → WB, repeated per neuron (K = fan-in), layer by layer; after the last L3 WB → DONE. DONE → IDLE on out_valid & out_ready.
- **BIAS:** acc ← bias sign-extended to 2W and shifted left by FRACTION_WIDTH.
- **MAC:** acc ← acc + x·w, where x·w is the full 2W-bit signed product; acc is 2W+4 bits wide.
- **WB:** result = acc >>> FRACTION_WIDTH (arithmetic, truncating toward −∞), reduced to W bits per Configuration.
  - Hidden layers: ReLU (negative → 0), stored in the activation buffer.
  - L3: no ReLU; loaded into out_score, out_class = (out_score > 0).

## Timing
- **Reset values:** in_ready = 1, out_valid = 0, out_score = 0, out_class = 0, FSM = IDLE.
- **Latency:** each neuron takes K+2 cycles. Total T = N_H1(N_IN+2) + N_H2(N_H1+2) + (N_H2+2); default T = 51.
  - With acceptance at edge E0, out_valid rises at edge E0+T, together with valid out_score/out_class.
- **Input handshake:** in_ready = 1 only in IDLE; it drops at the accepting edge.
- **Output handshake**
  - out_valid, out_score and out_class hold stable until out_ready is sampled high.
  - in_ready returns at that same edge, so back-to-back accept is possible on the following edge.
- **rst mid-inference:** immediate (asynchronous) return to reset values; the partial result is discarded; weights are retained.
- **Priority:** w_we is ignored at the accepting edge and in every non-IDLE cycle.

## Configuration
- **MLP_SAT_EN defined:** WB clamps to [−2^(W−1), 2^(W−1)−1] (0x80000 / 0x7FFFF at defaults) before ReLU.
- **MLP_SAT_EN undefined:** WB keeps the low W bits (two's-complement wrap).

## Test plan
All values use the default parameters; 1.0 = 0x10000.

- **Positive bias, class 1:** all weights 0, addr 38 = 1.0, inputs 0 → out_valid at E0+51, out_score = 0x10000, out_class = 1.
- **Negative bias, class 0:** addr 38 = −1.0 (0xF0000), everything else 0 → out_score = 0xF0000, out_class = 0.
- **ReLU path:** addr 1 = 1.0, addr 21 = 1.0, addr 39 = 1.0, rest 0.
  - inp_0 = 2.0 → score 0x20000, class 1.
  - inp_0 = −2.0 → score 0, class 0 (0 is not > 0).
- **Saturation:** same weights as the ReLU case but addr 1 = 7.0, inp_0 = 7.0.
  - MLP_SAT_EN defined → score 0x7FFFF.
  - MLP_SAT_EN undefined → L1 wraps 0x310000 to 0x10000 → score 0x10000.
- **Backpressure:** out_ready low for 10 cycles after out_valid → outputs stable, in_ready = 0, a second in_valid is not accepted.
  - out_ready high → in_ready = 1 the next cycle; the next vector completes 51 cycles after its acceptance.
- **Reset mid-run:** pulse rst at E0+20 → in_ready = 1 and out_valid = 0 without waiting for a clock edge.
  - Rerunning the ReLU-path vector without reloading weights → score 0x20000.
  - A w_we issued mid-inference has no effect on the result.
